// File: rtl/down_counter_ctrl_pkg.sv
// Shared types and defaults for the down_counter_ctrl timer slice.
//   state_t          : FSM state encoding (IDLE=0, RUN=1, PAUSE=2)
//   WIDTH_DEF        : default counter / load value width
//   PRESCALE_DEF     : default clk cycles per count tick
//   presc_width()    : prescaler register width, never below 1 bit
package down_counter_ctrl_pkg;

    localparam int unsigned WIDTH_DEF    = 4;
    localparam int unsigned PRESCALE_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    function automatic int unsigned presc_width(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/down_counter_ctrl_if.sv
// Control/status bundle between a controlling agent (master) and the timer (slave).
//   load_val, start, pause, abort, auto_reload : master -> timer
//   count, busy, done                          : timer -> master
interface down_counter_ctrl_if
    import down_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load_val, start, pause, abort, auto_reload,
        input  count, busy, done
    );

    modport slave (
        input  load_val, start, pause, abort, auto_reload,
        output count, busy, done
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk into count ticks: one tick every PRESCALE enabled cycles.
//   clk   : system clock
//   rst   : async active-low reset
//   en    : advance the prescaler this cycle (held value when low)
//   clr   : synchronous clear to 0, overrides en
//   tick  : high in the enabled cycle where the prescaler sits at PRESCALE-1
module tick_prescaler
    import down_counter_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEF
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned PW = presc_width(PRESCALE);

    logic [PW-1:0] cnt_q;
    logic          last_c;

    assign last_c = (cnt_q == PW'(PRESCALE - 1));
    assign tick   = en && last_c;

    // Wraps to 0 on the tick cycle so back-to-back periods have no gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= last_c ? '0 : cnt_q + PW'(1);
        end
    end
endmodule

// File: rtl/down_counter_ctrl.sv
// Programmable countdown timer: load, prescaled decrement, pause, abort, auto-reload,
// one-cycle done pulse at terminal count.
//   clk  : system clock, rising edge
//   rst  : async active-low reset
//   bus  : slave side of down_counter_ctrl_if (load_val/start/pause/abort/auto_reload in,
//          count/busy/done out, all outputs registered)
module down_counter_ctrl
    import down_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned PRESCALE = PRESCALE_DEF
)(
    input  logic                clk,
    input  logic                rst,
    down_counter_ctrl_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             start_ok_c;
    logic             en_c;
    logic             clr_c;
    logic             tick_c;

    // A start with a zero load only pulses done and never enters RUN.
    assign start_ok_c = (state_q == ST_IDLE) && bus.start && (bus.load_val != '0);
    // Prescaler freezes on pause so resume continues mid-period.
    assign en_c       = (state_q == ST_RUN) && !bus.pause && !bus.abort;
    assign clr_c      = bus.abort || start_ok_c;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en_c),
        .clr  (clr_c),
        .tick (tick_c)
    );

    // Next-state logic; priority abort > start > pause > tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (start_ok_c) begin
                            count_d  = bus.load_val;
                            reload_d = bus.load_val;
                            state_d  = ST_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick_c) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            done_d = 1'b1;
                            if (bus.auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
